// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID decoupling buffer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package if_id_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int ENTRY_W = INSTR_W + PC_W;

    // sll $0,$0,0 encodes as all zeros; decode sees this while the buffer is empty.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // One buffered fetch result: instruction word plus the PC+4 that accompanies it.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc_plus4;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_fifo_mem.sv
// DEPTH x ENTRY_W storage array: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none here; the owner gates the write enable.
// Ports: Clk; wr_en_i/wr_idx_i/wr_dat_i write side; rd_idx_i -> rd_dat_o read side.
// The data is deliberately not reset: occupancy is tracked by the owner's pointers.
module if_id_fifo_mem
    import if_id_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic              Clk,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_idx_i,
    input  if_id_entry_t      wr_dat_i,
    input  logic [AW-1:0]     rd_idx_i,
    output if_id_entry_t      rd_dat_o
);

    if_id_entry_t mem_q [DEPTH];

    always_ff @(posedge Clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_dat_i;
        end
    end

    assign rd_dat_o = mem_q[rd_idx_i];

endmodule

// File: rtl/if_id_buffer.sv
// IF->ID decoupling FIFO: holds up to DEPTH {instr, PC+4} entries, flushes on redirect, counts decode stalls.
// Latency: push-to-DecodeValid 1 cycle, no fall-through; pop-to-next-head 1 cycle.
// Backpressure: FetchReady = !full; head is held while DecodeReady=0; Flush overrides push and pop.
// Ports: Clk/Reset; fetch side FetchValid/Instruction/NextInstruct/FetchReady;
//        decode side DecodeValid/DecodeInstruction/DecodePCPlus4/DecodeReady; Flush; StallCount; Level.
module if_id_buffer
    import if_id_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       FetchValid,
    input  logic [INSTR_W-1:0]         Instruction,
    input  logic [PC_W-1:0]            NextInstruct,
    output logic                       FetchReady,
    output logic                       DecodeValid,
    output logic [INSTR_W-1:0]         DecodeInstruction,
    output logic [PC_W-1:0]            DecodePCPlus4,
    input  logic                       DecodeReady,
    input  logic                       Flush,
    output logic [CNT_W-1:0]           StallCount,
    output logic [$clog2(DEPTH):0]     Level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] stall_q,  stall_d;

    logic         full;
    logic         empty;
    logic         push;
    logic         pop;
    logic         stall;
    if_id_entry_t wr_entry;
    if_id_entry_t head_entry;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[AW-1:0]  == rd_ptr_q[AW-1:0]);

    assign push  = FetchValid  & ~full  & ~Flush;
    assign pop   = ~empty & DecodeReady & ~Flush;
    assign stall = ~empty & ~DecodeReady & ~Flush;

    assign wr_entry.instr    = Instruction;
    assign wr_entry.pc_plus4 = NextInstruct;

    if_id_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .Clk      (Clk),
        .wr_en_i  (push),
        .wr_idx_i (wr_ptr_q[AW-1:0]),
        .wr_dat_i (wr_entry),
        .rd_idx_i (rd_ptr_q[AW-1:0]),
        .rd_dat_o (head_entry)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        stall_d  = stall_q;

        if (Flush) begin
            // Redirect: every buffered instruction is on the wrong path.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end

        // Stall history survives redirects; it only saturates.
        if (stall && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_ONE;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            stall_q  <= stall_d;
        end
    end

    assign FetchReady        = ~full;
    assign DecodeValid       = ~empty;
    assign DecodeInstruction = empty ? NOP_INSTR : head_entry.instr;
    assign DecodePCPlus4     = empty ? '0        : head_entry.pc_plus4;
    assign StallCount        = stall_q;
    // Modulo subtraction of wrap-bit pointers yields 0..DEPTH directly.
    assign Level             = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer (DEPTH=2, CNT_W=4 so saturation is reachable quickly).
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
module tb_if_id_buffer;

    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic        Clk;
    logic        Reset;
    logic        FetchValid;
    logic [31:0] Instruction;
    logic [31:0] NextInstruct;
    logic        FetchReady;
    logic        DecodeValid;
    logic [31:0] DecodeInstruction;
    logic [31:0] DecodePCPlus4;
    logic        DecodeReady;
    logic        Flush;
    logic [CNT_W-1:0] StallCount;
    logic [1:0]  Level;

    int vectors;
    int miscompares;

    if_id_buffer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .FetchValid        (FetchValid),
        .Instruction       (Instruction),
        .NextInstruct      (NextInstruct),
        .FetchReady        (FetchReady),
        .DecodeValid       (DecodeValid),
        .DecodeInstruction (DecodeInstruction),
        .DecodePCPlus4     (DecodePCPlus4),
        .DecodeReady       (DecodeReady),
        .Flush             (Flush),
        .StallCount        (StallCount),
        .Level             (Level)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [31:0] ins,
                            input logic [31:0] pc, input logic [1:0] lvl);
        chk({tag, ".valid"}, {31'b0, DecodeValid},  {31'b0, v});
        chk({tag, ".instr"}, DecodeInstruction,     ins);
        chk({tag, ".pc4"},   DecodePCPlus4,         pc);
        chk({tag, ".level"}, {30'b0, Level},        {30'b0, lvl});
    endtask

    task automatic push_word(input logic [31:0] ins, input logic [31:0] pc);
        FetchValid   = 1'b1;
        Instruction  = ins;
        NextInstruct = pc;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        Reset        = 1'b0;
        FetchValid   = 1'b0;
        Instruction  = '0;
        NextInstruct = '0;
        DecodeReady  = 1'b0;
        Flush        = 1'b0;

        // Reset state
        #3;
        chk_head("rst", 1'b0, 32'h0, 32'h0, 2'd0);
        chk("rst.fready", {31'b0, FetchReady}, 32'h1);
        chk("rst.stall",  {28'b0, StallCount}, 32'h0);
        step();
        Reset = 1'b1;

        // Single push, consumed immediately
        push_word(32'h2008_0005, 32'h0000_0004);
        DecodeReady = 1'b1;
        step();
        FetchValid = 1'b0;
        chk_head("single", 1'b1, 32'h2008_0005, 32'h4, 2'd1);
        step();
        chk_head("single.nop", 1'b0, 32'h0, 32'h0, 2'd0);
        chk("single.stall", {28'b0, StallCount}, 32'h0);

        // Fill with DecodeReady=0; third push refused
        DecodeReady = 1'b0;
        push_word(32'h1111_1111, 32'h8);
        step();
        chk_head("fillA", 1'b1, 32'h1111_1111, 32'h8, 2'd1);
        chk("fillA.fready", {31'b0, FetchReady}, 32'h1);
        push_word(32'h2222_2222, 32'hC);
        step();                                   // stall 1
        chk("fillB.fready", {31'b0, FetchReady}, 32'h0);
        chk_head("fillB", 1'b1, 32'h1111_1111, 32'h8, 2'd2);
        push_word(32'h3333_3333, 32'h10);
        step();                                   // stall 2, push refused
        chk_head("fillC", 1'b1, 32'h1111_1111, 32'h8, 2'd2);
        FetchValid  = 1'b0;
        DecodeReady = 1'b1;
        step();
        chk_head("popA", 1'b1, 32'h2222_2222, 32'hC, 2'd1);
        chk("popA.fready", {31'b0, FetchReady}, 32'h1);
        step();
        chk_head("popB", 1'b0, 32'h0, 32'h0, 2'd0);
        chk("popB.stall", {28'b0, StallCount}, 32'h2);

        // Fill and stall for 5 cycles from first valid-not-ready edge
        DecodeReady = 1'b0;
        push_word(32'h4444_4444, 32'h14);
        step();                                   // DecodeValid was 0: no stall
        chk("stall.d", {28'b0, StallCount}, 32'h2);
        push_word(32'h5555_5555, 32'h18);
        step();                                   // stall 3
        FetchValid = 1'b0;
        for (int i = 0; i < 4; i++) step();      // stall 4..7
        chk("stall.five", {28'b0, StallCount}, 32'h7);
        chk_head("stall.head", 1'b1, 32'h4444_4444, 32'h14, 2'd2);

        // Flush with concurrent push while full-stalled
        Flush = 1'b1;
        push_word(32'h9999_9999, 32'h99);
        step();
        Flush      = 1'b0;
        FetchValid = 1'b0;
        chk_head("flush", 1'b0, 32'h0, 32'h0, 2'd0);
        chk("flush.fready", {31'b0, FetchReady}, 32'h1);
        chk("flush.stall",  {28'b0, StallCount}, 32'h7);

        // Push right after flush, then saturate the counter
        push_word(32'h6666_6666, 32'h1C);
        step();
        FetchValid = 1'b0;
        chk_head("postflush", 1'b1, 32'h6666_6666, 32'h1C, 2'd1);
        for (int i = 0; i < 7; i++) step();      // stall 8..14
        chk("sat.14", {28'b0, StallCount}, 32'hE);
        for (int i = 0; i < 13; i++) step();     // 20 stall cycles total
        chk("sat.15", {28'b0, StallCount}, 32'hF);
        DecodeReady = 1'b1;
        step();
        chk_head("sat.drain", 1'b0, 32'h0, 32'h0, 2'd0);

        // Streaming: one word per cycle, pointers wrap several times
        for (int i = 0; i < 8; i++) begin
            push_word(32'h1000_0000 + i, 32'(4 * (i + 1)));
            step();
            chk_head("stream", 1'b1, 32'h1000_0000 + i, 32'(4 * (i + 1)), 2'd1);
        end
        FetchValid = 1'b0;
        step();
        chk_head("stream.end", 1'b0, 32'h0, 32'h0, 2'd0);

        // Asynchronous reset between edges while holding data
        DecodeReady = 1'b0;
        push_word(32'h7777_7777, 32'h40);
        step();
        push_word(32'h8888_8888, 32'h44);
        step();
        FetchValid = 1'b0;
        chk_head("prearst", 1'b1, 32'h7777_7777, 32'h40, 2'd2);
        #2;
        Reset = 1'b0;
        #1;
        chk_head("arst", 1'b0, 32'h0, 32'h0, 2'd0);
        chk("arst.fready", {31'b0, FetchReady}, 32'h1);
        chk("arst.stall",  {28'b0, StallCount}, 32'h0);
        #1;
        Reset = 1'b1;
        push_word(32'hAAAA_AAAA, 32'h48);
        step();
        FetchValid = 1'b0;
        chk_head("postrst", 1'b1, 32'hAAAA_AAAA, 32'h48, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
